// File: rtl/instr_decode_stage_pkg.sv
// rtl/instr_decode_stage_pkg.sv - shared opcode constants and decoded-instruction struct
//
// Purpose: opcode and R-type ext encodings plus the packed decoded record
//          that is held in both the main and the skid registers.
package instr_decode_stage_pkg;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ANDI  = 4'h1;
    localparam logic [3:0] OP_ORI   = 4'h2;
    localparam logic [3:0] OP_XORI  = 4'h3;
    localparam logic [3:0] OP_MEM   = 4'h4;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_SHIFT = 4'h8;
    localparam logic [3:0] OP_CMPI  = 4'hB;
    localparam logic [3:0] OP_BCOND = 4'hC;
    localparam logic [3:0] OP_LUI   = 4'hF;

    localparam logic [3:0] EXT_LOAD = 4'h0;
    localparam logic [3:0] EXT_CMP  = 4'hB;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] ext;
        logic [3:0] rdest;
        logic [3:0] rsrc;
        logic       is_imm;
        logic       imm_zext;
        logic       is_branch;
        logic       is_mem;
        logic       wr_en;
        logic       illegal;
    } decoded_t;

endpackage

// File: rtl/instr_field_decoder.sv
// rtl/instr_field_decoder.sv - combinational instruction word to decoded record
//
// Purpose: splits a 16-bit instruction into fields and classification flags.
// Ports:
//   instr  in   16-bit instruction word
//   dec    out  decoded fields and flags
module instr_field_decoder
    import instr_decode_stage_pkg::*;
(
    input  logic [15:0] instr,
    output decoded_t    dec
);

    logic [3:0] op;
    logic [3:0] ex;
    logic       bad;

    assign op = instr[15:12];
    assign ex = instr[7:4];

    // Holes in the R-type ext space; such words still flow through the stage.
    assign bad = (op == OP_RTYPE) &&
                 (ex == 4'h4 || ex == 4'h8 || ex == 4'hC || ex == 4'hF);

    always_comb begin
        dec           = '0;
        dec.opcode    = op;
        dec.ext       = ex;
        dec.rdest     = instr[11:8];
        dec.rsrc      = instr[3:0];
        dec.illegal   = bad;
        dec.is_imm    = !(op == OP_RTYPE || op == OP_MEM ||
                          op == OP_SHIFT || op == OP_BCOND);
        dec.imm_zext  = (op == OP_ANDI || op == OP_ORI ||
                         op == OP_XORI || op == OP_LUI);
        dec.is_branch = (op == OP_BCOND);
        dec.is_mem    = (op == OP_MEM);
        // Only LOAD in the memory group writes a register.
        dec.wr_en     = !((op == OP_RTYPE && ex == EXT_CMP) ||
                          (op == OP_CMPI) ||
                          (op == OP_BCOND) ||
                          (op == OP_MEM && ex != EXT_LOAD) ||
                          bad);
    end

endmodule

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - decode pipeline stage with 2-entry skid buffer
//
// Purpose: decodes the incoming instruction and holds up to two decoded
//          records (main M drives outputs, skid S absorbs backpressure) so
//          that in_ready can be a flop.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   in_instr, in_valid, in_ready   upstream handshake
//   flush                          discard all held instructions
//   out_valid, out_ready           downstream handshake
//   opcode, ext, rdest, rsrc       instruction fields
//   imm_hi, imm_lo                 immediate nibbles for the sign extender
//   is_imm, imm_zext, is_branch,
//   is_mem, wr_en, illegal         classification flags
//   retired                        count of output handshakes (wraps)
module instr_decode_stage
    import instr_decode_stage_pkg::*;
#(
    parameter int IW    = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IW-1:0]    in_instr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       opcode,
    output logic [3:0]       ext,
    output logic [3:0]       rdest,
    output logic [3:0]       rsrc,
    output logic [3:0]       imm_hi,
    output logic [3:0]       imm_lo,
    output logic             is_imm,
    output logic             imm_zext,
    output logic             is_branch,
    output logic             is_mem,
    output logic             wr_en,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    decoded_t in_dec;
    decoded_t m_data;
    decoded_t s_data;
    logic     m_valid;
    logic     s_valid;
    logic     rdy_q;

    logic     accept;
    logic     xfer;
    logic     m_valid_n;
    logic     s_valid_n;
    logic     load_m_in;
    logic     load_m_skid;
    logic     load_s;

    instr_field_decoder u_dec (
        .instr (in_instr),
        .dec   (in_dec)
    );

    assign accept = in_valid && rdy_q;
    assign xfer   = m_valid && out_ready;

    // rdy_q mirrors !s_valid, so an accept never coincides with a full skid.
    always_comb begin
        m_valid_n   = m_valid;
        s_valid_n   = s_valid;
        load_m_in   = 1'b0;
        load_m_skid = 1'b0;
        load_s      = 1'b0;
        if (flush) begin
            m_valid_n = 1'b0;
            s_valid_n = 1'b0;
        end else if (xfer) begin
            if (s_valid) begin
                load_m_skid = 1'b1;
                s_valid_n   = 1'b0;
            end else if (accept) begin
                load_m_in = 1'b1;
            end else begin
                m_valid_n = 1'b0;
            end
        end else if (accept) begin
            if (m_valid) begin
                load_s    = 1'b1;
                s_valid_n = 1'b1;
            end else begin
                load_m_in = 1'b1;
                m_valid_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            rdy_q   <= 1'b1;
            m_data  <= '0;
            s_data  <= '0;
            retired <= '0;
        end else begin
            m_valid <= m_valid_n;
            s_valid <= s_valid_n;
            rdy_q   <= !s_valid_n;
            if (load_m_in)
                m_data <= in_dec;
            else if (load_m_skid)
                m_data <= s_data;
            if (load_s)
                s_data <= in_dec;
            // The record in M is discarded by a flush, so it does not retire.
            if (xfer && !flush)
                retired <= retired + CNT_W'(1);
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = m_valid;
    assign opcode    = m_data.opcode;
    assign ext       = m_data.ext;
    assign rdest     = m_data.rdest;
    assign rsrc      = m_data.rsrc;
    assign imm_hi    = m_data.ext;
    assign imm_lo    = m_data.rsrc;
    assign is_imm    = m_data.is_imm;
    assign imm_zext  = m_data.imm_zext;
    assign is_branch = m_data.is_branch;
    assign is_mem    = m_data.is_mem;
    assign wr_en     = m_data.wr_en;
    assign illegal   = m_data.illegal;

endmodule
